// File: rtl/instr_encoder.sv
// Instruction encoder: packs field sets into 16-bit words, buffers four, writes them out one by one.
// Optional macro INSTR_ENC_FLAG_EN places I_flag in bit [8]; otherwise bit [8] is 0.
module instr_encoder (
   input  logic        I_clk,
   input  logic        I_rst_n,
   input  logic        I_enable,
   input  logic        I_valid,
   output logic        O_ready,
   input  logic [3:0]  I_opcode,
   input  logic [2:0]  I_rD_select,
   input  logic [2:0]  I_rA_select,
   input  logic [2:0]  I_rB_select,
   input  logic [7:0]  I_immediate,
   input  logic        I_imm_form,
   input  logic        I_flag,
   output logic        O_mem_we,
   output logic [7:0]  O_mem_addr,
   output logic [15:0] O_mem_data,
   input  logic        I_mem_ack,
   output logic        O_wrap,
   output logic [2:0]  O_level
);

   typedef enum logic {ST_IDLE, ST_WRITE} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_fifo [4];
   logic [1:0]  r_wr_ptr;
   logic [1:0]  r_rd_ptr;
   logic [2:0]  r_count;
   logic [7:0]  r_addr;
   logic [15:0] r_data;
   logic        r_wrap;
   logic        w_push;
   logic        w_pop;
   logic        w_ack_done;
   logic        w_flag;
   logic [15:0] w_word;

`ifdef INSTR_ENC_FLAG_EN
   assign w_flag = I_flag;
`else
   // Flag feature absent: the input is tied off so bit [8] is always 0.
   assign w_flag = I_flag & 1'b0;
`endif

   assign w_word = {I_opcode, I_rD_select, w_flag,
                    I_imm_form ? I_immediate : {I_rA_select, I_rB_select, 2'b00}};

   assign O_ready = I_enable && (r_count < 3'd4);
   assign w_push  = I_valid && O_ready;

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_ack_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (I_enable && (r_count != 3'd0)) begin
               w_pop        = 1'b1;
               w_state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (I_mem_ack) begin
               w_ack_done   = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
      endcase
   end

   // Storage has no reset: clearing the pointers and count is enough to discard contents.
   always_ff @(posedge I_clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= w_word;
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_wr_ptr <= 2'd0;
         r_rd_ptr <= 2'd0;
         r_count  <= 3'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 2'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_data <= 16'h0000;
         r_addr <= 8'h00;
         r_wrap <= 1'b0;
      end else begin
         if (w_pop) begin
            r_data <= r_fifo[r_rd_ptr];
         end
         if (w_ack_done) begin
            r_addr <= r_addr + 8'd1;
            if (r_addr == 8'hFF) begin
               r_wrap <= 1'b1;
            end
         end
      end
   end

   // Write strobe comes straight from the state so reset removes it without waiting for a clock.
   assign O_mem_we   = (r_state == ST_WRITE);
   assign O_mem_addr = r_addr;
   assign O_mem_data = r_data;
   assign O_wrap     = r_wrap;
   assign O_level    = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// checked against a queue-based model of the encoder's behaviour.
module tb_instr_encoder;

   logic        I_clk = 1'b0;
   logic        I_rst_n = 1'b0;
   logic        I_enable = 1'b0;
   logic        I_valid = 1'b0;
   logic        O_ready;
   logic [3:0]  I_opcode = '0;
   logic [2:0]  I_rD_select = '0;
   logic [2:0]  I_rA_select = '0;
   logic [2:0]  I_rB_select = '0;
   logic [7:0]  I_immediate = '0;
   logic        I_imm_form = 1'b0;
   logic        I_flag = 1'b0;
   logic        O_mem_we;
   logic [7:0]  O_mem_addr;
   logic [15:0] O_mem_data;
   logic        I_mem_ack = 1'b0;
   logic        O_wrap;
   logic [2:0]  O_level;

   always #5 I_clk = ~I_clk;

   instr_encoder dut (
      .I_clk(I_clk), .I_rst_n(I_rst_n), .I_enable(I_enable), .I_valid(I_valid),
      .O_ready(O_ready), .I_opcode(I_opcode), .I_rD_select(I_rD_select),
      .I_rA_select(I_rA_select), .I_rB_select(I_rB_select), .I_immediate(I_immediate),
      .I_imm_form(I_imm_form), .I_flag(I_flag), .O_mem_we(O_mem_we),
      .O_mem_addr(O_mem_addr), .O_mem_data(O_mem_data), .I_mem_ack(I_mem_ack),
      .O_wrap(O_wrap), .O_level(O_level)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_writes = 0;
   logic [15:0] m_fifo [$];
   bit          m_busy;
   logic [15:0] m_cur;
   logic [7:0]  m_addr;
   bit          m_wrap;
   bit          ev_acc;

   // Reference encoding built from field arithmetic.
   function automatic logic [15:0] enc_word(input int op, input int rd, input int ra,
                                            input int rb, input int imm, input int form,
                                            input int flag);
      int w;
      w = op * 4096 + rd * 512 + ((form != 0) ? imm : (ra * 32 + rb * 4));
`ifdef INSTR_ENC_FLAG_EN
      w = w + flag * 256;
`endif
      return 16'(w);
   endfunction

   task automatic rand_fields();
      I_opcode    = 4'($urandom);
      I_rD_select = 3'($urandom);
      I_rA_select = 3'($urandom);
      I_rB_select = 3'($urandom);
      I_immediate = 8'($urandom);
      I_imm_form  = 1'($urandom);
      I_flag      = 1'($urandom);
   endtask

   task automatic model_clear();
      m_fifo.delete();
      m_busy = 0; m_cur = '0; m_addr = '0; m_wrap = 0; ev_acc = 0;
   endtask

   // Advances one clock and updates the model; returns 1 ns after the edge.
   task automatic clock_edge();
      bit acc, done, pop;
      logic [15:0] word;
      acc  = I_valid && I_enable && (m_fifo.size() < 4);
      done = m_busy && I_mem_ack;
      pop  = !m_busy && I_enable && (m_fifo.size() > 0);
      word = enc_word(int'(I_opcode), int'(I_rD_select), int'(I_rA_select), int'(I_rB_select),
                      int'(I_immediate), int'(I_imm_form), int'(I_flag));
      @(posedge I_clk);
      #1;
      ev_acc = acc;
      if (done) begin
         n_writes++;
         $display("write %0d: addr=%0d data=%04h", n_writes, m_addr, m_cur);
         m_busy = 0;
         if (m_addr == 8'hFF) m_wrap = 1;
         m_addr = m_addr + 8'd1;
      end
      if (pop) begin
         m_cur  = m_fifo.pop_front();
         m_busy = 1;
      end
      if (acc) m_fifo.push_back(word);
   endtask

   task automatic do_reset();
      I_rst_n = 0; I_valid = 0; I_enable = 0; I_mem_ack = 0;
      repeat (2) @(posedge I_clk);
      #1;
      I_rst_n = 1;
      model_clear();
   endtask

   task automatic test_reset();
      I_rst_n = 0; I_enable = 1; I_valid = 1; I_mem_ack = 1;
      rand_fields();
      repeat (3) @(posedge I_clk);
      #1;
      n_cmp++; if (O_mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", O_mem_we); end
      n_cmp++; if (O_mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", O_mem_addr); end
      n_cmp++; if (O_mem_data !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %04h want 0000", O_mem_data); end
      n_cmp++; if (O_level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", O_level); end
      n_cmp++; if (O_wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", O_wrap); end
      I_valid = 0;
      I_rst_n = 1;
      model_clear();
      #1;
      n_cmp++; if (O_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", O_ready); end
   endtask

   task automatic test_imm_format();
      do_reset();
      I_enable = 1; I_mem_ack = 1;
      rand_fields();
      I_opcode = 4'hA; I_rD_select = 3'd3; I_immediate = 8'h5C; I_imm_form = 1; I_flag = 0;
      I_valid = 1;
      clock_edge();
      I_valid = 0;
      n_cmp++; if (O_level !== 3'd1) begin n_bad++; $display("FAIL imm_level: got %0d want 1", O_level); end
      clock_edge();
      n_cmp++; if (O_mem_we !== 1'b1) begin n_bad++; $display("FAIL imm_we: got %b want 1", O_mem_we); end
      n_cmp++; if (O_mem_data !== 16'hA65C) begin n_bad++; $display("FAIL imm_data: got %04h want A65C", O_mem_data); end
      n_cmp++; if (O_mem_addr !== 8'd0) begin n_bad++; $display("FAIL imm_addr0: got %0d want 0", O_mem_addr); end
      clock_edge();
      n_cmp++; if (O_mem_we !== 1'b0) begin n_bad++; $display("FAIL imm_we_drop: got %b want 0", O_mem_we); end
      n_cmp++; if (O_mem_addr !== 8'd1) begin n_bad++; $display("FAIL imm_addr1: got %0d want 1", O_mem_addr); end
   endtask

   task automatic test_reg_format();
      do_reset();
      I_enable = 1; I_mem_ack = 1;
      I_opcode = 4'h3; I_rD_select = 3'd1; I_rA_select = 3'd5; I_rB_select = 3'd6;
      I_immediate = 8'hFF; I_imm_form = 0; I_flag = 0;
      I_valid = 1;
      clock_edge();
      I_valid = 0;
      clock_edge();
      n_cmp++; if (O_mem_data !== 16'h32B8) begin n_bad++; $display("FAIL reg_data: got %04h want 32B8", O_mem_data); end
      clock_edge();
   endtask

   task automatic test_flag();
      logic [15:0] want;
`ifdef INSTR_ENC_FLAG_EN
      want = 16'h0100;
`else
      want = 16'h0000;
`endif
      do_reset();
      I_enable = 1; I_mem_ack = 1;
      I_opcode = 0; I_rD_select = 0; I_rA_select = 0; I_rB_select = 0;
      I_immediate = 0; I_imm_form = 0; I_flag = 1;
      I_valid = 1;
      clock_edge();
      I_valid = 0; I_flag = 0;
      clock_edge();
      n_cmp++; if (O_mem_data !== want) begin n_bad++; $display("FAIL flag_data: got %04h want %04h", O_mem_data, want); end
      clock_edge();
   endtask

   task automatic test_backpressure();
      int k;
      do_reset();
      I_enable = 1; I_mem_ack = 0;
      for (int i = 0; i < 6; i++) begin
         rand_fields();
         I_valid = 1;
         clock_edge();
      end
      n_cmp++; if (O_level !== 3'd4) begin n_bad++; $display("FAIL bp_level: got %0d want 4", O_level); end
      n_cmp++; if (O_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready: got %b want 0", O_ready); end
      n_cmp++; if (O_mem_we !== 1'b1) begin n_bad++; $display("FAIL bp_we: got %b want 1", O_mem_we); end
      I_mem_ack = 1;
      k = 0;
      for (int c = 0; c < 60 && k < 6; c++) begin
         if (O_mem_we === 1'b1) begin
            n_cmp++; if (O_mem_data !== m_cur) begin n_bad++; $display("FAIL bp_data%0d: got %04h want %04h", k, O_mem_data, m_cur); end
            n_cmp++; if (O_mem_addr !== 8'(k)) begin n_bad++; $display("FAIL bp_addr%0d: got %0d want %0d", k, O_mem_addr, k); end
            k++;
         end
         clock_edge();
         if (ev_acc) I_valid = 0;
      end
      n_cmp++; if (k !== 6) begin n_bad++; $display("FAIL bp_count: got %0d writes want 6", k); end
   endtask

   task automatic test_enable_gate();
      do_reset();
      I_enable = 0; I_mem_ack = 0; I_valid = 1;
      rand_fields();
      repeat (3) clock_edge();
      n_cmp++; if (O_level !== 3'd0) begin n_bad++; $display("FAIL en_level: got %0d want 0", O_level); end
      n_cmp++; if (O_ready !== 1'b0) begin n_bad++; $display("FAIL en_ready: got %b want 0", O_ready); end
      n_cmp++; if (O_mem_we !== 1'b0) begin n_bad++; $display("FAIL en_we: got %b want 0", O_mem_we); end
      I_enable = 1;
      clock_edge();
      rand_fields();
      clock_edge();
      I_valid = 0; I_enable = 0;
      clock_edge();
      n_cmp++; if (O_mem_we !== 1'b1) begin n_bad++; $display("FAIL en_hold_we: got %b want 1", O_mem_we); end
      I_mem_ack = 1;
      clock_edge();
      n_cmp++; if (O_mem_we !== 1'b0 || O_mem_addr !== 8'd1) begin n_bad++; $display("FAIL en_complete: got we=%b addr=%0d want we=0 addr=1", O_mem_we, O_mem_addr); end
      I_mem_ack = 0;
      repeat (2) clock_edge();
      n_cmp++; if (O_mem_we !== 1'b0 || O_level !== 3'd1) begin n_bad++; $display("FAIL en_no_start: got we=%b level=%0d want we=0 level=1", O_mem_we, O_level); end
      I_enable = 1;
      clock_edge();
      n_cmp++; if (O_mem_we !== 1'b1 || O_mem_data !== m_cur) begin n_bad++; $display("FAIL en_restart: got we=%b data=%04h want we=1 data=%04h", O_mem_we, O_mem_data, m_cur); end
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      I_enable = 1; I_mem_ack = 1;
      rand_fields();
      I_valid = 1;
      clock_edge();
      I_valid = 0;
      repeat (2) clock_edge();
      I_mem_ack = 0;
      for (int i = 0; i < 4; i++) begin
         rand_fields();
         I_valid = 1;
         clock_edge();
      end
      I_valid = 0;
      n_cmp++; if (O_level !== 3'd3 || O_mem_we !== 1'b1 || O_mem_addr !== 8'd1) begin
         n_bad++; $display("FAIL rmw_pre: got level=%0d we=%b addr=%0d want 3 1 1", O_level, O_mem_we, O_mem_addr); end
      #2;
      I_rst_n = 0;
      #1;
      n_cmp++; if (O_mem_we !== 1'b0) begin n_bad++; $display("FAIL rmw_async_we: got %b want 0", O_mem_we); end
      @(posedge I_clk);
      #1;
      I_rst_n = 1;
      model_clear();
      clock_edge();
      n_cmp++; if (O_level !== 3'd0) begin n_bad++; $display("FAIL rmw_level: got %0d want 0", O_level); end
      n_cmp++; if (O_mem_addr !== 8'd0) begin n_bad++; $display("FAIL rmw_addr: got %0d want 0", O_mem_addr); end
      n_cmp++; if (O_mem_we !== 1'b0) begin n_bad++; $display("FAIL rmw_we: got %b want 0", O_mem_we); end
   endtask

   task automatic test_wrap();
      int k;
      do_reset();
      I_enable = 1; I_mem_ack = 1;
      k = 0;
      for (int c = 0; c < 1500 && k < 257; c++) begin
         rand_fields();
         I_valid = 1;
         if (O_mem_we === 1'b1) begin
            n_cmp++; if (O_mem_data !== m_cur) begin n_bad++; $display("FAIL wrap_data%0d: got %04h want %04h", k, O_mem_data, m_cur); end
            n_cmp++; if (O_mem_addr !== 8'(k)) begin n_bad++; $display("FAIL wrap_addr%0d: got %0d want %0d", k, O_mem_addr, k % 256); end
            n_cmp++; if (O_wrap !== (k >= 256)) begin n_bad++; $display("FAIL wrap_flag%0d: got %b want %b", k, O_wrap, k >= 256); end
            k++;
         end
         clock_edge();
      end
      I_valid = 0;
      n_cmp++; if (k !== 257) begin n_bad++; $display("FAIL wrap_count: got %0d writes want 257", k); end
      n_cmp++; if (O_wrap !== 1'b1) begin n_bad++; $display("FAIL wrap_sticky: got %b want 1", O_wrap); end
      n_cmp++; if (O_mem_addr !== 8'd1) begin n_bad++; $display("FAIL wrap_final_addr: got %0d want 1", O_mem_addr); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         I_enable  = ($urandom_range(9, 0) != 0);
         I_valid   = 1'($urandom_range(1, 0));
         I_mem_ack = ($urandom_range(2, 0) == 0);
         rand_fields();
         clock_edge();
         n_cmp++; if (O_mem_we !== m_busy) begin n_bad++; $display("FAIL rnd_we c=%0d: got %b want %b", c, O_mem_we, m_busy); end
         n_cmp++; if (O_level !== 3'(m_fifo.size())) begin n_bad++; $display("FAIL rnd_level c=%0d: got %0d want %0d", c, O_level, m_fifo.size()); end
         n_cmp++; if (O_mem_addr !== m_addr) begin n_bad++; $display("FAIL rnd_addr c=%0d: got %0d want %0d", c, O_mem_addr, m_addr); end
         n_cmp++; if (O_ready !== (I_enable && m_fifo.size() < 4)) begin n_bad++; $display("FAIL rnd_ready c=%0d: got %b", c, O_ready); end
         if (m_busy) begin
            n_cmp++; if (O_mem_data !== m_cur) begin n_bad++; $display("FAIL rnd_data c=%0d: got %04h want %04h", c, O_mem_data, m_cur); end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      test_reset();
      test_imm_format();
      test_reg_format();
      test_flag();
      test_backpressure();
      test_enable_gate();
      test_reset_mid_write();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
